// File: rtl/instr_sequencer_if.sv
// instr_sequencer_if: bundles every sequencer signal except clk/rst.
//   master modport : sequencer side (drives PM_Addr, Ins_Q, gated strobes, status)
//   slave modport  : environment side (program memory, decoder, data memory, control)
// Optional macro: SEQ_SINGLE_STEP_EN adds the Step input.
interface instr_sequencer_if #(
    parameter int unsigned PC_WIDTH  = 8,
    parameter int unsigned INS_WIDTH = 13,
    parameter int unsigned CNT_WIDTH = 16
);
    logic                 Run;
    logic                 HaltReq;
`ifdef SEQ_SINGLE_STEP_EN
    logic                 Step;
`endif
    logic [PC_WIDTH-1:0]  PM_Addr;
    logic [INS_WIDTH-1:0] PM_Ins;
    logic [INS_WIDTH-1:0] Ins_Q;
    logic                 Dec_DataMem_WE;
    logic                 Dec_Reg_CE;
    logic                 Dec_Carry_CE;
    logic                 Dec_Accu_CE;
    logic                 DataMem_WE;
    logic                 Reg_CE;
    logic                 Carry_CE;
    logic                 Accu_CE;
    logic                 DM_Ready;
    logic                 Busy;
    logic                 Halted;
    logic [CNT_WIDTH-1:0] Retired;

    modport master (
`ifdef SEQ_SINGLE_STEP_EN
        input  Step,
`endif
        input  Run, HaltReq, PM_Ins, DM_Ready,
        input  Dec_DataMem_WE, Dec_Reg_CE, Dec_Carry_CE, Dec_Accu_CE,
        output PM_Addr, Ins_Q, DataMem_WE, Reg_CE, Carry_CE, Accu_CE,
        output Busy, Halted, Retired
    );

    modport slave (
`ifdef SEQ_SINGLE_STEP_EN
        output Step,
`endif
        output Run, HaltReq, PM_Ins, DM_Ready,
        output Dec_DataMem_WE, Dec_Reg_CE, Dec_Carry_CE, Dec_Accu_CE,
        input  PM_Addr, Ins_Q, DataMem_WE, Reg_CE, Carry_CE, Accu_CE,
        input  Busy, Halted, Retired
    );
endinterface

// File: rtl/instr_sequencer.sv
// instr_sequencer: fetch/execute sequencer for the 13-bit micro-core.
// Owns the PC, loads the instruction register from program memory, gates the
// decoder strobes to a single completing execute cycle, implements JMP/HALT
// and stalls data-memory instructions until DM_Ready.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   bus      : instr_sequencer_if.master (PM bus, decoder strobes, DM_Ready,
//              Run/HaltReq control, Busy/Halted/Retired status)
// Optional macro: SEQ_SINGLE_STEP_EN enables the Step input (start one
// instruction from IDLE while Run is low).
module instr_sequencer #(
    parameter int unsigned PC_WIDTH  = 8,
    parameter int unsigned INS_WIDTH = 13,
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    instr_sequencer_if.master     bus
);
    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StFetch = 2'd1;
    localparam logic [1:0] StExec  = 2'd2;
    localparam logic [1:0] StHalt  = 2'd3;

    localparam logic [4:0] OpJmp  = 5'b11110;
    localparam logic [4:0] OpHalt = 5'b11111;
    localparam logic [4:0] OpLdDm = 5'b11001;
    localparam logic [4:0] OpStDm = 5'b11100;

    logic [1:0]           state_q, state_d;
    logic [PC_WIDTH-1:0]  pc_q, pc_d;
    logic [INS_WIDTH-1:0] ins_q, ins_d;
    logic [CNT_WIDTH-1:0] retired_q, retired_d;

    logic [4:0] opcode;
    logic       is_jmp, is_halt, is_dm;
    logic       exec_done;
    logic       strobe_en;
    logic       start;

    assign opcode  = ins_q[INS_WIDTH-1 -: 5];
    assign is_jmp  = (opcode == OpJmp);
    assign is_halt = (opcode == OpHalt);
    assign is_dm   = (opcode[4:3] == 2'b01) || (opcode == OpLdDm) || (opcode == OpStDm);

    // An EXEC cycle completes unless it is a HALT or a DM access still waiting.
    assign exec_done = (state_q == StExec) && !is_halt && !(is_dm && !bus.DM_Ready);
    // JMP completes but never lets decoder strobes through.
    assign strobe_en = exec_done && !is_jmp;

`ifdef SEQ_SINGLE_STEP_EN
    assign start = bus.Run || bus.Step;
`else
    assign start = bus.Run;
`endif

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        ins_d     = ins_q;
        retired_d = retired_q;
        case (state_q)
            StIdle: begin
                if (start) state_d = StFetch;
            end
            StFetch: begin
                ins_d   = bus.PM_Ins;
                state_d = StExec;
            end
            StExec: begin
                if (is_halt) begin
                    state_d = StHalt;
                end else if (exec_done) begin
                    pc_d      = is_jmp ? PC_WIDTH'(ins_q[7:0]) : pc_q + PC_WIDTH'(1);
                    retired_d = retired_q + CNT_WIDTH'(1);
                    if (bus.HaltReq)  state_d = StHalt;
                    else if (!bus.Run) state_d = StIdle;
                    else              state_d = StFetch;
                end
            end
            default: begin
                if (!bus.Run && !bus.HaltReq) state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            pc_q      <= '0;
            ins_q     <= '0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ins_q     <= ins_d;
            retired_q <= retired_d;
        end
    end

    assign bus.PM_Addr    = pc_q;
    assign bus.Ins_Q      = ins_q;
    assign bus.Busy       = (state_q == StFetch) || (state_q == StExec);
    assign bus.Halted     = (state_q == StHalt);
    assign bus.Retired    = retired_q;
    assign bus.DataMem_WE = strobe_en && bus.Dec_DataMem_WE;
    assign bus.Reg_CE     = strobe_en && bus.Dec_Reg_CE;
    assign bus.Carry_CE   = strobe_en && bus.Dec_Carry_CE;
    assign bus.Accu_CE    = strobe_en && bus.Dec_Accu_CE;
endmodule

// File: tb/tb_instr_sequencer.sv
// Randomized bench for instr_sequencer. The reference is a procedural
// instruction-level walk: idle wait, fetch, execute (with stalls), halt,
// with PC/Retired kept as plain integers.
module tb_instr_sequencer;
    localparam int PW = 8;
    localparam int IW = 13;
    localparam int CW = 16;

    localparam int PIdle  = 0;
    localparam int PFetch = 1;
    localparam int PExec  = 2;
    localparam int PHalt  = 3;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    instr_sequencer_if #(.PC_WIDTH(PW), .INS_WIDTH(IW), .CNT_WIDTH(CW)) bus ();

    instr_sequencer #(.PC_WIDTH(PW), .INS_WIDTH(IW), .CNT_WIDTH(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [IW-1:0] pm [256];
    assign bus.PM_Ins = pm[bus.PM_Addr];

    int n_vec = 0;
    int n_err = 0;

    int            m_pc, m_ret;
    logic [IW-1:0] m_ins;
    int            phase, nxt;
    int            mode;
    logic [3:0]    dec;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [IW-1:0] gen_ins();
        int r;
        logic [4:0] op;
        logic [7:0] dat;
        r   = $urandom_range(0, 31);
        dat = 8'($urandom);
        if (r == 0)     op = 5'b11111;
        else if (r < 3) op = 5'b11110;
        else            op = 5'($urandom_range(0, 29));
        return {op, dat};
    endfunction

    task automatic pick_inputs();
        dec = 4'($urandom);
        {bus.Dec_DataMem_WE, bus.Dec_Reg_CE, bus.Dec_Carry_CE, bus.Dec_Accu_CE} = dec;
`ifdef SEQ_SINGLE_STEP_EN
        bus.Step = 1'b0;
`endif
        if (mode == 0) begin
            bus.Run = 1'b1; bus.HaltReq = 1'b0; bus.DM_Ready = 1'b1;
        end else begin
            bus.DM_Ready = ($urandom_range(0, 9) < 7);
            if (phase == PHalt) begin
                bus.Run     = ($urandom_range(0, 9) < 3);
                bus.HaltReq = ($urandom_range(0, 9) < 3);
            end else begin
                bus.Run     = ($urandom_range(0, 9) < 9);
                bus.HaltReq = ($urandom_range(0, 19) == 0);
            end
`ifdef SEQ_SINGLE_STEP_EN
            bus.Step = ($urandom_range(0, 3) == 0);
`endif
        end
    endtask

    task automatic check_outputs(input logic busy, input logic halted, input logic sen);
        check("pm_addr", 32'(bus.PM_Addr), 32'(m_pc));
        check("retired", 32'(bus.Retired), 32'(m_ret));
        check("ins_q",   32'(bus.Ins_Q),   32'(m_ins));
        check("busy",    32'(bus.Busy),    32'(busy));
        check("halted",  32'(bus.Halted),  32'(halted));
        check("strobes", 32'({bus.DataMem_WE, bus.Reg_CE, bus.Carry_CE, bus.Accu_CE}),
              32'(sen ? dec : 4'h0));
    endtask

    initial begin
        logic [IW-1:0] fetched;
        logic [4:0]    op;
        logic          go, dm, done, stalled, rst_done;
        rst = 1'b1;
        mode = 0;
        phase = PIdle;
        stalled = 1'b0;
        rst_done = 1'b0;
        fetched = '0;
        m_pc = 0; m_ret = 0; m_ins = '0;
        for (int i = 0; i < 256; i++) pm[i] = gen_ins();
        pm[0] = {5'b10000, 8'h11};
        pm[1] = {5'b10000, 8'h22};
        pm[2] = {5'b11111, 8'h00};
        pick_inputs();
        repeat (2) @(posedge clk);
        #1;
        check_outputs(1'b0, 1'b0, 1'b0);
        rst = 1'b0;

        for (int cyc = 0; cyc < 6000; cyc++) begin
            pick_inputs();
            #1;
            go = bus.Run;
`ifdef SEQ_SINGLE_STEP_EN
            go = go || bus.Step;
`endif
            case (phase)
                PIdle: begin
                    check_outputs(1'b0, 1'b0, 1'b0);
                    nxt = go ? PFetch : PIdle;
                end
                PFetch: begin
                    check_outputs(1'b1, 1'b0, 1'b0);
                    fetched = pm[m_pc];
                    nxt = PExec;
                end
                PExec: begin
                    op   = m_ins[12:8];
                    dm   = (op[4:3] == 2'b01) || (op == 5'b11001) || (op == 5'b11100);
                    done = (op != 5'b11111) && !(dm && !bus.DM_Ready);
                    stalled = dm && !bus.DM_Ready && (op != 5'b11111);
                    check_outputs(1'b1, 1'b0, done && (op != 5'b11110));
                    if (op == 5'b11111) begin
                        nxt = PHalt;
                    end else if (done) begin
                        m_pc  = (op == 5'b11110) ? int'(m_ins[7:0]) : (m_pc + 1) % 256;
                        m_ret = (m_ret + 1) % 65536;
                        if (bus.HaltReq)  nxt = PHalt;
                        else if (!bus.Run) nxt = PIdle;
                        else              nxt = PFetch;
                    end else begin
                        nxt = PExec;
                    end
                end
                default: begin
                    check_outputs(1'b0, 1'b1, 1'b0);
                    nxt = (!bus.Run && !bus.HaltReq) ? PIdle : PHalt;
                end
            endcase
            @(posedge clk);
            #1;
            if (phase == PFetch) m_ins = fetched;
            if (phase != PExec) stalled = 1'b0;
            phase = nxt;

            if (mode == 0 && phase == PHalt) begin
                check("dir_retired", 32'(bus.Retired), 32'd2);
                check("dir_pc", 32'(bus.PM_Addr), 32'd2);
                check("dir_halted", 32'(bus.Halted), 32'd1);
                mode = 1;
                for (int i = 0; i < 256; i++) pm[i] = gen_ins();
                // Resume lands on a jump to the top of memory to force a PC wrap.
                pm[2]     = {5'b11110, 8'hFE};
                pm[8'hFE] = {5'b10000, 8'h01};
                pm[8'hFF] = {5'b10001, 8'h02};
            end

            if (mode == 1 && !rst_done && cyc > 1500 && phase == PExec && stalled) begin
                rst = 1'b1;
                {bus.Dec_DataMem_WE, bus.Dec_Reg_CE, bus.Dec_Carry_CE, bus.Dec_Accu_CE} = 4'hF;
                bus.DM_Ready = 1'b1;
                #1;
                check("rst_pm_addr", 32'(bus.PM_Addr), 32'd0);
                check("rst_ins_q",   32'(bus.Ins_Q),   32'd0);
                check("rst_busy",    32'(bus.Busy),    32'd0);
                check("rst_halted",  32'(bus.Halted),  32'd0);
                check("rst_retired", 32'(bus.Retired), 32'd0);
                check("rst_strobes",
                      32'({bus.DataMem_WE, bus.Reg_CE, bus.Carry_CE, bus.Accu_CE}), 32'd0);
                @(posedge clk);
                #1;
                rst = 1'b0;
                m_pc = 0; m_ret = 0; m_ins = '0;
                phase = PIdle;
                stalled = 1'b0;
                rst_done = 1'b1;
            end
        end
        check("reset_injected", 32'(rst_done), 32'd1);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
